// File: rtl/snoop_responder.sv
// Cache-side MSI snoop responder: looks up the dcache tags, reports the snoop result, writes back a
// dirty block as two words and downgrades/invalidates the line. Optional macro: LLSC_SNOOP_EN.
module snoop_responder #(
    parameter int unsigned IDX_W = 3,
    parameter int unsigned WAYS  = 2,
    parameter int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
    parameter int unsigned TAG_W = 32 - IDX_W - 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ccwait,
    input  logic             ccinv,
    input  logic [31:0]      ccsnoopaddr,
    output logic             ccwrite,
    output logic             cctrans,
    output logic [31:0]      snp_daddr,
    output logic [31:0]      snp_dstore,
    input  logic             snp_wack,
    output logic [IDX_W-1:0] lk_idx,
    output logic [TAG_W-1:0] lk_tag,
    input  logic             lk_hit,
    input  logic [WAY_W-1:0] lk_way,
    input  logic [1:0]       lk_state,
    output logic             rd_blkoff,
    input  logic [31:0]      rd_data,
    output logic             upd_en,
    output logic [WAY_W-1:0] upd_way,
    output logic [1:0]       upd_state,
`ifdef LLSC_SNOOP_EN
    input  logic             link_valid,
    input  logic [31:0]      link_addr,
    output logic             link_clr,
`endif
    output logic             core_hold
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLookup = 3'd1;
    localparam logic [2:0] StResp   = 3'd2;
    localparam logic [2:0] StWb1    = 3'd3;
    localparam logic [2:0] StWb2    = 3'd4;
    localparam logic [2:0] StDone   = 3'd5;

    localparam logic [1:0] LineI = 2'd0;
    localparam logic [1:0] LineS = 2'd1;
    localparam logic [1:0] LineM = 2'd2;

    logic [2:0]       state_q, state_d;
    logic [31:3]      addr_q, addr_d;
    logic             inv_q, inv_d;
    logic             hit_q, hit_d;
    logic [WAY_W-1:0] way_q, way_d;
    logic [1:0]       lstate_q, lstate_d;
    logic             armed_q, armed_d;
    logic             line_m;
    logic             do_upd;

    // Byte/word offset within the block is irrelevant to a snoop.
    logic unused_addr;
    assign unused_addr = ^ccsnoopaddr[2:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            inv_q    <= 1'b0;
            hit_q    <= 1'b0;
            way_q    <= '0;
            lstate_q <= LineI;
            armed_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            inv_q    <= inv_d;
            hit_q    <= hit_d;
            way_q    <= way_d;
            lstate_q <= lstate_d;
            armed_q  <= armed_d;
        end
    end

    assign line_m = hit_q && (lstate_q == LineM);
    assign do_upd = hit_q && ((lstate_q == LineM) || ((lstate_q == LineS) && inv_q));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        inv_d    = inv_q;
        hit_d    = hit_q;
        way_d    = way_q;
        lstate_d = lstate_q;
        armed_d  = armed_q;
        case (state_q)
            StIdle: begin
                // armed stops a strobe that stays high from starting a second snoop
                if (ccwait && armed_q) begin
                    addr_d  = ccsnoopaddr[31:3];
                    inv_d   = ccinv;
                    armed_d = 1'b0;
                    state_d = StLookup;
                end else if (!ccwait) begin
                    armed_d = 1'b1;
                end
            end
            StLookup: begin
                hit_d    = lk_hit;
                way_d    = lk_way;
                lstate_d = lk_state;
                state_d  = StResp;
            end
            StResp:  state_d = line_m ? StWb1 : StDone;
            StWb1:   if (snp_wack) state_d = StWb2;
            StWb2:   if (snp_wack) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ccwrite    = 1'b0;
        cctrans    = 1'b0;
        snp_daddr  = '0;
        snp_dstore = '0;
        lk_idx     = '0;
        lk_tag     = '0;
        rd_blkoff  = 1'b0;
        upd_en     = 1'b0;
        upd_way    = '0;
        upd_state  = LineI;
        core_hold  = (state_q != StIdle);
        case (state_q)
            StLookup: begin
                lk_idx = addr_q[IDX_W+2:3];
                lk_tag = addr_q[31:IDX_W+3];
            end
            StResp: begin
                cctrans = 1'b1;
                ccwrite = line_m;
            end
            StWb1: begin
                ccwrite    = 1'b1;
                snp_daddr  = {addr_q[31:3], 3'b000};
                snp_dstore = rd_data;
            end
            StWb2: begin
                ccwrite    = 1'b1;
                snp_daddr  = {addr_q[31:3], 3'b100};
                rd_blkoff  = 1'b1;
                snp_dstore = rd_data;
            end
            StDone: begin
                if (do_upd) begin
                    upd_en    = 1'b1;
                    upd_way   = way_q;
                    upd_state = (line_m && !inv_q) ? LineS : LineI;
                end
            end
            default: ;
        endcase
    end

`ifdef LLSC_SNOOP_EN
    // Losing the line to another writer breaks any reservation on the same block.
    logic unused_link;
    assign unused_link = ^link_addr[2:0];
    assign link_clr = (state_q == StDone) && inv_q && link_valid &&
                      (link_addr[31:3] == addr_q[31:3]);
`endif

endmodule
